// File: rtl/uart_cmd_tx.sv
// ----------------------------------------------------------------------------
// uart_cmd_tx
// ----------------------------------------------------------------------------
// Sends a six-bit robot command as one 8N1 UART byte. A new frame goes out
// whenever the command differs from the byte most recently sent. The current
// byte is also resent once per refresh period so that a receiver which missed
// a frame catches up again.
//
// Parameters
//   CLKS_PER_BIT    sys_clk cycles per UART bit
//   REFRESH_CYCLES  sys_clk cycles between forced resends of the current byte
//
// Ports
//   sys_clk                 in   system clock, all logic on the rising edge
//   rst                     in   synchronous active-high reset
//   en                      in   transmit enable, 0 blocks new frame launches
//   move_forward_signal     in   command bit 0
//   move_backward_signal    in   command bit 1
//   turn_left_signal        in   command bit 2
//   turn_right_signal       in   command bit 3
//   place_barrier_signal    in   command bit 4
//   destroy_barrier_signal  in   command bit 5
//   tx                      out  UART serial line, idle high
//   busy                    out  high while a frame is on the line
//   frame_done              out  one-cycle pulse in the last cycle of STOP
//   last_byte               out  byte most recently launched
// ----------------------------------------------------------------------------
module uart_cmd_tx #(
   parameter int CLKS_PER_BIT   = 10416,
   parameter int REFRESH_CYCLES = 10000000
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       en,
   input  logic       move_forward_signal,
   input  logic       move_backward_signal,
   input  logic       turn_left_signal,
   input  logic       turn_right_signal,
   input  logic       place_barrier_signal,
   input  logic       destroy_barrier_signal,
   output logic       tx,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] last_byte
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_PRE = CNT_W'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
   localparam logic             ONE_CLK_BIT = (CLKS_PER_BIT == 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic [REF_W-1:0] refresh_cnt;
   logic             refresh_pending;

   logic [7:0]       cmd_byte;
   logic             bit_end;
   logic             refresh_wrap;
   logic             launch;

   // The command byte is assembled straight from the inputs, which already
   // live in the sys_clk domain. The two top bits are reserved and always 0.
   assign cmd_byte = {2'b00,
                      destroy_barrier_signal,
                      place_barrier_signal,
                      turn_right_signal,
                      turn_left_signal,
                      move_backward_signal,
                      move_forward_signal};

   // A frame starts only from IDLE, only while enabled, and only if there is
   // something worth sending: a changed command or an expired refresh period.
   // Changes that happen during a frame are picked up here afterwards, so
   // intermediate values may never reach the line.
   assign bit_end      = (clk_cnt == BIT_LAST);
   assign refresh_wrap = (refresh_cnt == REF_LAST);
   assign launch       = (state == IDLE) && en &&
                         ((cmd_byte != last_byte) || refresh_pending);

   // Free-running refresh timer. The pending flag survives any length of
   // disabled time and is cleared only by a launch; a wrap landing on the
   // launch cycle wins so that the next period is not lost.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         refresh_cnt     <= '0;
         refresh_pending <= 1'b0;
      end else begin
         if (refresh_wrap) begin
            refresh_cnt <= '0;
         end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
         end

         if (refresh_wrap) begin
            refresh_pending <= 1'b1;
         end else if (launch) begin
            refresh_pending <= 1'b0;
         end
      end
   end

   // Frame sequencer. Every output is a register so tx never glitches.
   // Each state holds for CLKS_PER_BIT cycles; the bit value is loaded into
   // tx on the edge that enters the bit, which is why tx goes low the cycle
   // after a launch. frame_done is raised one cycle early so that it is high
   // exactly during the final STOP cycle, letting the next frame launch in
   // the very next cycle.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         last_byte  <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               tx         <= 1'b1;
               busy       <= 1'b0;
               frame_done <= 1'b0;
               clk_cnt    <= '0;
               bit_idx    <= '0;
               if (launch) begin
                  state     <= START;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  shift_reg <= cmd_byte;
                  last_byte <= cmd_byte;
               end
            end

            START: begin
               if (bit_end) begin
                  state     <= DATA;
                  clk_cnt   <= '0;
                  bit_idx   <= '0;
                  tx        <= shift_reg[0];
                  shift_reg <= {1'b0, shift_reg[7:1]};
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state      <= STOP;
                     tx         <= 1'b1;
                     frame_done <= ONE_CLK_BIT;
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     tx        <= shift_reg[0];
                     shift_reg <= {1'b0, shift_reg[7:1]};
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            STOP: begin
               if (bit_end) begin
                  state      <= IDLE;
                  clk_cnt    <= '0;
                  busy       <= 1'b0;
                  frame_done <= 1'b0;
               end else begin
                  clk_cnt    <= clk_cnt + CNT_W'(1);
                  frame_done <= (clk_cnt == STOP_PRE);
               end
            end

            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_tx
// ----------------------------------------------------------------------------
// Directed bench for uart_cmd_tx with a short bit time and refresh period.
// Each step that should cause a frame pushes the expected byte to exp_q.
// A line monitor decodes every frame on tx, checks it cycle by cycle against
// the byte at the head of the queue and pops it when the frame completes.
// ----------------------------------------------------------------------------
module tb_uart_cmd_tx;

   localparam int CPB       = 4;
   localparam int REFRESH   = 200;
   localparam int FRAME_LEN = 10 * CPB;

   logic       sys_clk;
   logic       rst;
   logic       en;
   logic       move_forward_signal;
   logic       move_backward_signal;
   logic       turn_left_signal;
   logic       turn_right_signal;
   logic       place_barrier_signal;
   logic       destroy_barrier_signal;
   logic       tx;
   logic       busy;
   logic       frame_done;
   logic [7:0] last_byte;

   int         n_compared   = 0;
   int         n_mismatched = 0;
   int         cyc          = 0;
   int         since_rst    = 0;
   int         frames_seen  = 0;
   int         expect_interval = 0;
   logic [7:0] exp_q[$];

   uart_cmd_tx #(
      .CLKS_PER_BIT   (CPB),
      .REFRESH_CYCLES (REFRESH)
   ) dut (
      .sys_clk                (sys_clk),
      .rst                    (rst),
      .en                     (en),
      .move_forward_signal    (move_forward_signal),
      .move_backward_signal   (move_backward_signal),
      .turn_left_signal       (turn_left_signal),
      .turn_right_signal      (turn_right_signal),
      .place_barrier_signal   (place_barrier_signal),
      .destroy_barrier_signal (destroy_barrier_signal),
      .tx                     (tx),
      .busy                   (busy),
      .frame_done             (frame_done),
      .last_byte              (last_byte)
   );

   // 100 MHz clock.
   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Cycle counter plus a count of edges since the last reset edge, which
   // tracks where the refresh period stands.
   always @(posedge sys_clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         since_rst <= 0;
      end else begin
         since_rst <= since_rst + 1;
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #(20000 * 10);
      $display("[TB] FAIL watchdog: simulation time limit reached, observed running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      assert (observed === expected)
      else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] cmd, input logic en_v);
      move_forward_signal    = cmd[0];
      move_backward_signal   = cmd[1];
      turn_left_signal       = cmd[2];
      turn_right_signal      = cmd[3];
      place_barrier_signal   = cmd[4];
      destroy_barrier_signal = cmd[5];
      en                     = en_v;
   endtask

   task automatic stepCycle();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic waitFrameDone(input string tag);
      int n = 0;
      while (frame_done !== 1'b1 && n < 3 * FRAME_LEN) begin
         stepCycle();
         n++;
      end
      checkOutput(tag, {31'd0, frame_done}, 32'd1);
   endtask

   task automatic checkQuiet(input int cycles, input string tag);
      int bad = 0;
      repeat (cycles) begin
         stepCycle();
         if (busy !== 1'b0 || tx !== 1'b1) bad++;
      end
      checkOutput(tag, bad, 0);
   endtask

   // Line monitor: decodes each frame and checks start bit, data bits
   // (LSB first), stop bit, busy and the frame_done pulse against the
   // expected byte. A reset aborts any frame being tracked.
   initial begin : line_monitor
      bit         active;
      bit         have_exp;
      bit         have_start;
      int         idx;
      int         bitpos;
      int         last_start;
      logic [7:0] exp_byte;
      logic [7:0] rx_byte;
      logic       exp_tx;
      active     = 1'b0;
      have_exp   = 1'b0;
      have_start = 1'b0;
      idx        = 0;
      last_start = 0;
      exp_byte   = 8'h00;
      rx_byte    = 8'h00;
      forever begin
         @(negedge sys_clk);
         if (rst !== 1'b0) begin
            active     = 1'b0;
            have_start = 1'b0;
         end else begin
            if (!active && tx === 1'b0) begin
               active = 1'b1;
               idx    = 1;
               rx_byte = 8'h00;
               frames_seen++;
               if (have_start && expect_interval != 0) begin
                  checkOutput("refresh_interval", cyc - last_start, expect_interval);
               end
               last_start = cyc;
               have_start = 1'b1;
               checkOutput("frame_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
               have_exp = (exp_q.size() != 0);
               if (have_exp) begin
                  exp_byte = exp_q[0];
                  checkOutput($sformatf("last_byte_at_start_%02h", exp_byte), last_byte, exp_byte);
               end
            end
            if (active) begin
               bitpos = (idx - 1) / CPB;
               if (bitpos == 0) begin
                  exp_tx = 1'b0;
               end else if (bitpos == 9) begin
                  exp_tx = 1'b1;
               end else begin
                  exp_tx = exp_byte[bitpos-1];
               end
               if (bitpos >= 1 && bitpos <= 8 && ((idx - 1) % CPB) == 0) begin
                  rx_byte[bitpos-1] = tx;
               end
               if (have_exp) begin
                  checkOutput($sformatf("tx_cycle%0d_byte%02h", idx, exp_byte), {31'd0, tx}, {31'd0, exp_tx});
               end
               checkOutput($sformatf("busy_cycle%0d", idx), {31'd0, busy}, 32'd1);
               checkOutput($sformatf("frame_done_cycle%0d", idx), {31'd0, frame_done}, {31'd0, (idx == FRAME_LEN)});
               if (idx == FRAME_LEN) begin
                  active = 1'b0;
                  if (have_exp) begin
                     checkOutput("frame_byte", rx_byte, exp_byte);
                     void'(exp_q.pop_front());
                  end
               end
               idx++;
            end else begin
               checkOutput("idle_frame_done", {31'd0, frame_done}, 32'd0);
            end
         end
      end
   end

   // Directed scenario sequence.
   initial begin : stimulus
      int start_frames;
      int guard;
      int bad;

      // Reset with all inputs low: outputs at their reset values.
      rst = 1'b1;
      applyStimulus(6'h00, 1'b1);
      repeat (3) stepCycle();
      checkOutput("reset_tx", {31'd0, tx}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_frame_done", {31'd0, frame_done}, 32'd0);
      checkOutput("reset_last_byte", last_byte, 8'h00);

      // Idle command equal to last_byte: nothing is sent within 150 cycles.
      rst = 1'b0;
      checkQuiet(150, "s1_quiet");
      checkOutput("s1_no_frames", frames_seen, 0);

      // Forward + left (0x05) launches on the first cycle out of reset.
      rst = 1'b1;
      applyStimulus(6'h05, 1'b1);
      repeat (2) stepCycle();
      exp_q.push_back(8'h05);
      rst = 1'b0;
      stepCycle();
      checkOutput("s2_busy_after_launch", {31'd0, busy}, 32'd1);
      checkOutput("s2_tx_start", {31'd0, tx}, 32'd0);
      checkOutput("s2_last_byte", last_byte, 8'h05);

      // Mid-frame change to 0x3F must not disturb the 0x05 frame.
      repeat (19) stepCycle();
      applyStimulus(6'h3F, 1'b1);
      exp_q.push_back(8'h3F);
      waitFrameDone("s2_done_05");
      checkOutput("s2_last_byte_held", last_byte, 8'h05);
      stepCycle();
      checkOutput("s2_gap_busy", {31'd0, busy}, 32'd0);
      checkOutput("s2_gap_tx", {31'd0, tx}, 32'd1);
      stepCycle();
      checkOutput("s2_next_busy", {31'd0, busy}, 32'd1);
      checkOutput("s2_next_tx", {31'd0, tx}, 32'd0);
      checkOutput("s2_next_last_byte", last_byte, 8'h3F);
      waitFrameDone("s2_done_3f");
      checkQuiet(50, "s2_quiet_after");

      // Static 0x12: one frame at launch and one per refresh wrap.
      rst = 1'b1;
      applyStimulus(6'h12, 1'b1);
      expect_interval = REFRESH;
      repeat (2) stepCycle();
      start_frames = frames_seen;
      repeat (4) exp_q.push_back(8'h12);
      rst = 1'b0;
      repeat (660) stepCycle();
      checkOutput("s3_frame_count", frames_seen - start_frames, 4);
      checkOutput("s3_queue_drained", exp_q.size(), 0);
      expect_interval = 0;

      // Reset during data bit 3 aborts the frame; 0x08 launches right after.
      rst = 1'b1;
      applyStimulus(6'h12, 1'b1);
      repeat (2) stepCycle();
      exp_q.push_back(8'h12);
      rst = 1'b0;
      stepCycle();
      checkOutput("s4_busy_first", {31'd0, busy}, 32'd1);
      repeat (17) stepCycle();
      rst = 1'b1;
      applyStimulus(6'h08, 1'b1);
      exp_q.delete();
      stepCycle();
      checkOutput("s4_abort_tx", {31'd0, tx}, 32'd1);
      checkOutput("s4_abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("s4_abort_last_byte", last_byte, 8'h00);
      checkOutput("s4_abort_frame_done", {31'd0, frame_done}, 32'd0);
      exp_q.push_back(8'h08);
      rst = 1'b0;
      stepCycle();
      checkOutput("s4_relaunch_busy", {31'd0, busy}, 32'd1);
      checkOutput("s4_relaunch_tx", {31'd0, tx}, 32'd0);
      checkOutput("s4_relaunch_last_byte", last_byte, 8'h08);
      waitFrameDone("s4_done_08");
      repeat (3) stepCycle();

      // Disabled: a changed command waits until en returns.
      applyStimulus(6'h30, 1'b0);
      checkQuiet(30, "s5_disabled_quiet");
      exp_q.push_back(8'h30);
      applyStimulus(6'h30, 1'b1);
      stepCycle();
      checkOutput("s5_enable_busy", {31'd0, busy}, 32'd1);
      checkOutput("s5_enable_last_byte", last_byte, 8'h30);
      repeat (4) stepCycle();
      applyStimulus(6'h30, 1'b0);
      waitFrameDone("s5_done_30");

      // Still disabled across a refresh wrap: the resend is held back.
      guard = 0;
      bad   = 0;
      while (since_rst < REFRESH + 30 && guard < 400) begin
         stepCycle();
         if (busy !== 1'b0 || tx !== 1'b1) bad++;
         guard++;
      end
      checkOutput("s5_held_quiet", bad, 0);
      checkOutput("s5_past_wrap", {31'd0, (since_rst >= REFRESH + 30)}, 32'd1);
      exp_q.push_back(8'h30);
      applyStimulus(6'h30, 1'b1);
      stepCycle();
      checkOutput("s5_pending_busy", {31'd0, busy}, 32'd1);
      waitFrameDone("s5_done_refresh");
      checkQuiet(40, "s5_quiet_after");
      checkOutput("final_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
